ct_seq: RTL and testbench

- Sequential, parametrised successor to the team's combinational calculator (CT).
- Accepts NUM unsigned operands of WIDTH bits plus an opcode through a valid/ready handshake.
- Sorts the operands internally with an odd-even transposition network, one pass per cycle, then computes one of four reductions.
- Presents the result with a one-cycle out_valid pulse after a fixed latency.

---
 rtl/ct_seq.sv | 150 +++++++++++++++
 tb/tb_ct_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ct_seq.sv
// rtl/ct_seq.sv - sequential sort-and-reduce calculator
// Latches NUM unsigned operands plus an opcode. Sorts them ascending with an
// odd-even transposition network, one pass per cycle. Then computes SUM,
// RANGE, MEDIAN or WSUM and presents the result for one cycle.
// Optional feature macro: CT_SEQ_SAT_EN. When it is defined, SUM/WSUM
// overflow clamps to all ones instead of wrapping.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   input handshake (in_ready high only when idle)
//   opcode[2:0]          [1:0] operation, [2] WSUM weight order
//   in_data              NUM packed operands, operand 0 in the LSBs
//   out_valid, out_n     one-cycle result pulse; out_n is 0 otherwise
module ct_seq #(
    parameter int NUM   = 6,
    parameter int WIDTH = 4,
    parameter int OUT_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           opcode,
    input  logic [NUM*WIDTH-1:0] in_data,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_n
);

    localparam int CNT_W = $clog2(NUM);
    // The weight sum 1+..+NUM is below (NUM+1)^2, so this width holds WSUM exactly.
    localparam int ACC_B = WIDTH + 2 * $clog2(NUM + 1) + 1;
    localparam int ACC_W = (ACC_B > OUT_W) ? ACC_B : OUT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SORT,
        S_CALC,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] s_q [NUM];
    logic [WIDTH-1:0] s_d [NUM];
    logic [OUT_W-1:0] res_q, res_d;
    logic [ACC_W-1:0] full;
    logic [OUT_W-1:0] reduced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            for (int i = 0; i < NUM; i++) begin
                s_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
            s_q     <= s_d;
        end
    end

    // Full-precision reduction over the sorted registers.
    always_comb begin
        full = '0;
        case (op_q[1:0])
            2'b00: begin
                for (int i = 0; i < NUM; i++) begin
                    full = full + ACC_W'(s_q[i]);
                end
            end
            2'b01: full = ACC_W'(s_q[NUM-1]) - ACC_W'(s_q[0]);
            2'b10: full = ACC_W'(s_q[NUM/2]);
            default: begin
                for (int i = 0; i < NUM; i++) begin
                    full = full + ACC_W'(s_q[i]) *
                           (op_q[2] ? ACC_W'(NUM - i) : ACC_W'(i + 1));
                end
            end
        endcase
    end

    // RANGE and MEDIAN always fit, so only SUM/WSUM can be affected here.
    always_comb begin
`ifdef CT_SEQ_SAT_EN
        if (full > ACC_W'({OUT_W{1'b1}})) begin
            reduced = '1;
        end else begin
            reduced = full[OUT_W-1:0];
        end
`else
        reduced = full[OUT_W-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;
        s_d     = s_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < NUM; i++) begin
                        s_d[i] = in_data[i*WIDTH +: WIDTH];
                    end
                    op_d    = opcode;
                    cnt_d   = '0;
                    state_d = S_SORT;
                end
            end
            S_SORT: begin
                // Even passes pair (0,1),(2,3)..; odd passes pair (1,2),(3,4)..
                // Pairs within a pass are disjoint, so each one reads s_q directly.
                for (int i = 0; i < NUM - 1; i++) begin
                    if (((i % 2) == int'(cnt_q[0])) && (s_q[i] > s_q[i+1])) begin
                        s_d[i]   = s_q[i+1];
                        s_d[i+1] = s_q[i];
                    end
                end
                if (cnt_q == CNT_W'(NUM - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CALC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CALC: begin
                res_d   = reduced;
                state_d = S_OUT;
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_n     = out_valid ? res_q : '0;

endmodule

// File: tb/tb_ct_seq.sv
// tb/tb_ct_seq.sv - self-checking bench for ct_seq (OUT_W=9 and OUT_W=8 instances)
module tb_ct_seq;

    localparam int N = 6;
    localparam int W = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [2:0]    opcode;
    logic [N*W-1:0] in_data;
    logic          in_ready, in_ready8;
    logic          out_valid, out_valid8;
    logic [8:0]    out_n;
    logic [7:0]    out_n8;

    ct_seq #(.NUM(N), .WIDTH(W), .OUT_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .in_data(in_data), .out_valid(out_valid), .out_n(out_n)
    );

    ct_seq #(.NUM(N), .WIDTH(W), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .opcode(opcode), .in_data(in_data), .out_valid(out_valid8), .out_n(out_n8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: sort a copy, then apply the operation with plain arithmetic.
    function automatic int model(input logic [N*W-1:0] d, input logic [2:0] op, input int ow);
        int q[$];
        int v;
        int lim;
        for (int i = 0; i < N; i++) q.push_back(int'(d[i*W +: W]));
        q.sort();
        v = 0;
        case (op[1:0])
            2'd0: foreach (q[i]) v += q[i];
            2'd1: v = q[N-1] - q[0];
            2'd2: v = q[N/2];
            default: foreach (q[i]) v += q[i] * (op[2] ? (N - i) : (i + 1));
        endcase
        lim = (1 << ow) - 1;
`ifdef CT_SEQ_SAT_EN
        if (v > lim) return lim;
`endif
        return v % (1 << ow);
    endfunction

    typedef struct {
        int due;
        int r9;
        int r8;
    } exp_t;

    exp_t expq[$];
    int   n       = 0;
    int   free_at = 0;
    int   last9   = -1;
    int   last8   = -1;

    // Cycle-level model of the handshake and result timing, sampled on negedge.
    always @(negedge clk) begin
        bit exp_ready;
        bit exp_v;
        n++;
        if (!rst_n) begin
            chk("rst_ready", int'(in_ready), 1);
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_out", int'(out_n), 0);
            chk("rst_valid8", int'(out_valid8), 0);
            expq.delete();
            free_at = 0;
        end else begin
            exp_ready = (n >= free_at);
            chk("in_ready", int'(in_ready), int'(exp_ready));
            chk("in_ready8", int'(in_ready8), int'(exp_ready));
            exp_v = (expq.size() > 0) && (expq[0].due == n);
            chk("out_valid", int'(out_valid), int'(exp_v));
            chk("out_valid8", int'(out_valid8), int'(exp_v));
            if (exp_v) begin
                chk("out_n", int'(out_n), expq[0].r9);
                chk("out_n8", int'(out_n8), expq[0].r8);
                last9 = int'(out_n);
                last8 = int'(out_n8);
                void'(expq.pop_front());
            end else begin
                chk("idle_out", int'(out_n), 0);
                chk("idle_out8", int'(out_n8), 0);
            end
            if (exp_ready && in_valid) begin
                expq.push_back('{due: n + N + 2, r9: model(in_data, opcode, 9),
                                 r8: model(in_data, opcode, 8)});
                free_at = n + N + 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N*W-1:0] d, input logic [2:0] op);
        in_data  = d;
        opcode   = op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
    endtask

    localparam logic [N*W-1:0] OPS_A = 24'h47F193; // {3,9,1,15,7,4}
    localparam logic [N*W-1:0] ALL_F = 24'hFFFFFF;
    localparam logic [N*W-1:0] FIVES = 24'h555555;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = '0;
        in_data  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        send(OPS_A, 3'b000); chk("sum", last9, 39);
        send(OPS_A, 3'b001); chk("range", last9, 14);
        send(OPS_A, 3'b010); chk("median", last9, 7);
        send(OPS_A, 3'b011); chk("wsum_asc", last9, 182);
        send(OPS_A, 3'b111); chk("wsum_desc", last9, 91);
        send(OPS_A, 3'b101); chk("range_op2", last9, 14);

        // Busy rejection: a second request during SORT must be ignored.
        in_data = OPS_A; opcode = 3'b001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        in_data = 24'h123456; opcode = 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("busy_range", last9, 14);

        // Back-to-back with in_valid held; data changes while busy.
        in_data = OPS_A; opcode = 3'b011; in_valid = 1'b1;
        tick();
        in_data = FIVES; opcode = 3'b011;
        repeat (9) tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("b2b_second", last9, 105);

        // Overflow on the 8-bit instance.
        send(ALL_F, 3'b011);
`ifdef CT_SEQ_SAT_EN
        chk("ovf_wsum8", last8, 255);
`else
        chk("ovf_wsum8", last8, 59);
`endif
        chk("ovf_wsum9", last9, 315);
        send(ALL_F, 3'b000); chk("ovf_sum8", last8, 90);

        // Ties and extremes.
        send('0, 3'b000); chk("zero_sum", last9, 0);
        send('0, 3'b001); chk("zero_range", last9, 0);
        send('0, 3'b010); chk("zero_med", last9, 0);
        send('0, 3'b011); chk("zero_wsum", last9, 0);
        send('0, 3'b111); chk("zero_wsumd", last9, 0);
        send(FIVES, 3'b001); chk("five_range", last9, 0);
        send(FIVES, 3'b010); chk("five_med", last9, 5);
        send(FIVES, 3'b111); chk("five_wsum", last9, 105);

        // Reset during SORT aborts the job at once.
        in_data = OPS_A; opcode = 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("async_ready", int'(in_ready), 1);
        chk("async_valid", int'(out_valid), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();

        // Randomized traffic against the model.
        repeat (400) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 24'($urandom);
            opcode   = 3'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (12) tick();
        chk("drain", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
